// File: rtl/integrate_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module      : integrator_pkg
// Description : Shared types and helpers for the integrate-and-dump block.
//               FSM state enum and signed min/max limit functions for a
//               given two's-complement width.
// Revision    : 1.0 - initial release
// ============================================================================
package integrator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        ACCUM = 2'd2
    } state_t;

    // Largest value representable in a signed field of width w (w <= 31).
    function automatic int signed s_max(input int w);
        return (1 <<< (w - 1)) - 1;
    endfunction

    // Smallest value representable in a signed field of width w (w <= 31).
    function automatic int signed s_min(input int w);
        return -(1 <<< (w - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/integrate_dump_if.sv
`default_nettype none
// ============================================================================
// Module      : integrate_dump_if
// Description : Sample-stream and frame-result bundle for integrate_dump.
//               master : drives en_i/len_i/data_i/valid_i, observes results
//               slave  : the integrator side
//   en_i    block enable (low = clear and idle)
//   len_i   samples per frame, unsigned (0 treated as 1)
//   data_i  signed input sample,   valid_i input strobe
//   data_o  signed frame sum,      valid_o one-cycle dump pulse
//   ovf_o   sticky overflow flag
// Revision    : 1.0 - initial release
// ============================================================================
interface integrate_dump_if #(
    parameter int I_BW   = 5,
    parameter int O_BW   = 8,
    parameter int CNT_BW = 8
) ();
    logic              en_i;
    logic [CNT_BW-1:0] len_i;
    logic [I_BW-1:0]   data_i;
    logic              valid_i;
    logic [O_BW-1:0]   data_o;
    logic              valid_o;
    logic              ovf_o;

    modport master (
        output en_i, len_i, data_i, valid_i,
        input  data_o, valid_o, ovf_o
    );

    modport slave (
        input  en_i, len_i, data_i, valid_i,
        output data_o, valid_o, ovf_o
    );
endinterface
`default_nettype wire

// File: rtl/integrate_dump_add_sat.sv
`default_nettype none
// ============================================================================
// Module      : integrator_add_sat
// Description : Combinational accumulator adder. Sign-extends both operands
//               to O_BW+1 bits, flags overflow when the result leaves the
//               O_BW signed range, and returns either the wrapped or the
//               clamped O_BW-bit result.
//   i_acc  O_BW signed accumulator   i_data I_BW signed sample
//   o_sum  O_BW signed result        o_ovf  overflow detected
// Config      : INTEGRATE_DUMP_SATURATE_EN defined -> clamp, else wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module integrator_add_sat
    import integrator_pkg::*;
#(
    parameter int I_BW = 5,
    parameter int O_BW = 8
) (
    input  wire logic [O_BW-1:0] i_acc,
    input  wire logic [I_BW-1:0] i_data,
    output logic      [O_BW-1:0] o_sum,
    output logic                 o_ovf
);

    logic [O_BW:0] w_acc_ext;
    logic [O_BW:0] w_data_ext;
    logic [O_BW:0] w_sum_ext;

    assign w_acc_ext  = {i_acc[O_BW-1], i_acc};
    assign w_data_ext = {{(O_BW + 1 - I_BW){i_data[I_BW-1]}}, i_data};
    assign w_sum_ext  = w_acc_ext + w_data_ext;

    // Out of range exactly when the extra sign bit disagrees with the MSB.
    assign o_ovf = w_sum_ext[O_BW] ^ w_sum_ext[O_BW-1];

`ifdef INTEGRATE_DUMP_SATURATE_EN
    localparam logic [O_BW-1:0] c_MAX = O_BW'(s_max(O_BW));
    localparam logic [O_BW-1:0] c_MIN = O_BW'(s_min(O_BW));

    // The true sign of the sum is the extension bit.
    assign o_sum = !o_ovf         ? w_sum_ext[O_BW-1:0] :
                   w_sum_ext[O_BW] ? c_MIN : c_MAX;
`else
    assign o_sum = w_sum_ext[O_BW-1:0];
`endif

endmodule
`default_nettype wire

// File: rtl/integrate_dump.sv
`default_nettype none
// ============================================================================
// Module      : integrate_dump
// Description : Integrate-and-dump accumulator. Sums len_q signed samples
//               per frame, then dumps the sum on data_o with a one-cycle
//               valid_o pulse. The accumulator restarts in the dump cycle so
//               back-to-back frames lose no samples.
//   clk_i    clock
//   rst_n_i  asynchronous active-low reset
//   bus      integrate_dump_if.slave (en/len/data/valid in, data/valid/ovf out)
// Config      : INTEGRATE_DUMP_SATURATE_EN selects clamping instead of wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module integrate_dump
    import integrator_pkg::*;
#(
    parameter int I_BW   = 5,
    parameter int O_BW   = 8,
    parameter int CNT_BW = 8
) (
    input  wire logic    clk_i,
    input  wire logic    rst_n_i,
    integrate_dump_if.slave bus
);

    state_t            r_state;
    logic [O_BW-1:0]   r_acc;
    logic [CNT_BW-1:0] r_cnt;
    logic [CNT_BW-1:0] r_len;
    logic [O_BW-1:0]   r_data;
    logic              r_valid;
    logic              r_ovf;

    logic              w_first;
    logic [O_BW-1:0]   w_acc_in;
    logic [O_BW-1:0]   w_sum;
    logic              w_ovf;
    logic [CNT_BW-1:0] w_len_eff;
    logic [CNT_BW-1:0] w_cnt_nxt;
    logic              w_last;

    assign w_first   = (r_state == FIRST);
    // The first sample of a frame starts from zero, whatever r_acc holds.
    assign w_acc_in  = w_first ? '0 : r_acc;
    assign w_len_eff = (bus.len_i == '0) ? CNT_BW'(1) : bus.len_i;
    assign w_cnt_nxt = r_cnt + CNT_BW'(1);
    // In FIRST the frame length is not latched yet, so use the live value.
    assign w_last    = w_first ? (w_len_eff == CNT_BW'(1)) : (w_cnt_nxt == r_len);

    integrator_add_sat #(
        .I_BW (I_BW),
        .O_BW (O_BW)
    ) u_add (
        .i_acc  (w_acc_in),
        .i_data (bus.data_i),
        .o_sum  (w_sum),
        .o_ovf  (w_ovf)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (!bus.en_i) begin
                // Partial frame discarded; data_o keeps the last dump.
                r_state <= IDLE;
                r_acc   <= '0;
                r_cnt   <= '0;
                r_ovf   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: r_state <= FIRST;
                    FIRST, ACCUM: begin
                        if (bus.valid_i) begin
                            if (w_first) r_len <= w_len_eff;
                            if (w_ovf)   r_ovf <= 1'b1;
                            if (w_last) begin
                                r_data  <= w_sum;
                                r_valid <= 1'b1;
                                r_acc   <= '0;
                                r_cnt   <= '0;
                                r_state <= FIRST;
                            end else begin
                                r_acc   <= w_sum;
                                r_cnt   <= w_cnt_nxt;
                                r_state <= ACCUM;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.data_o  = r_data;
    assign bus.valid_o = r_valid;
    assign bus.ovf_o   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_integrate_dump.sv
`default_nettype none
// ============================================================================
// Module      : tb_integrate_dump
// Description : Self-checking bench for integrate_dump. A frame-level
//               reference model (plain integer arithmetic) predicts data_o,
//               valid_o and ovf_o every cycle; directed frames follow the
//               test plan, then a randomized stream runs.
// Config      : INTEGRATE_DUMP_SATURATE_EN selects the clamping expectation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_integrate_dump;
    import integrator_pkg::*;

    localparam int I_BW   = 5;
    localparam int O_BW   = 8;
    localparam int CNT_BW = 8;
    localparam int c_MAXV = (1 <<< (O_BW - 1)) - 1;
    localparam int c_MINV = -(1 <<< (O_BW - 1));

    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b0;

    integrate_dump_if #(.I_BW(I_BW), .O_BW(O_BW), .CNT_BW(CNT_BW)) bus ();

    integrate_dump #(.I_BW(I_BW), .O_BW(O_BW), .CNT_BW(CNT_BW)) u_dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: frame progress, not hardware encoding.
    bit m_armed;   // block has been enabled for at least one full cycle
    int m_acc;
    int m_cnt;
    int m_len;
    int m_data;
    bit m_valid;
    bit m_ovf;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int wrap_o(input int s);
        int m;
        m = (s - c_MINV) % (1 <<< O_BW);
        if (m < 0) m += (1 <<< O_BW);
        return m + c_MINV;
    endfunction

    task automatic model_reset();
        m_armed = 0; m_acc = 0; m_cnt = 0; m_len = 0;
        m_data  = 0; m_valid = 0; m_ovf = 0;
    endtask

    // One clock edge of frame behaviour, using the inputs the DUT sees.
    task automatic model_step();
        int s;
        m_valid = 0;
        if (!rst_n_i) begin
            model_reset();
        end else if (!bus.en_i) begin
            m_armed = 0; m_acc = 0; m_cnt = 0; m_ovf = 0;
        end else if (!m_armed) begin
            m_armed = 1;
        end else if (bus.valid_i) begin
            if (m_cnt == 0) begin
                m_len = (int'(bus.len_i) == 0) ? 1 : int'(bus.len_i);
                m_acc = 0;
            end
            s = m_acc + int'($signed(bus.data_i));
            if (s > c_MAXV || s < c_MINV) begin
                m_ovf = 1;
`ifdef INTEGRATE_DUMP_SATURATE_EN
                s = (s > c_MAXV) ? c_MAXV : c_MINV;
`else
                s = wrap_o(s);
`endif
            end
            m_cnt++;
            if (m_cnt == m_len) begin
                m_data = s; m_valid = 1; m_cnt = 0; m_acc = 0;
            end else begin
                m_acc = s;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".data"},  int'($signed(bus.data_o)), m_data);
        check_val({tag, ".valid"}, int'(bus.valid_o), int'(m_valid));
        check_val({tag, ".ovf"},   int'(bus.ovf_o),   int'(m_ovf));
    endtask

    task automatic cycle();
        @(posedge clk_i);
        model_step();
        #1;
        check_outputs("cyc");
    endtask

    task automatic send(input int d);
        bus.valid_i = 1'b1;
        bus.data_i  = I_BW'(d);
        cycle();
        bus.valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.valid_i = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        model_reset();
        bus.en_i    = 1'b0;
        bus.len_i   = '0;
        bus.data_i  = '0;
        bus.valid_i = 1'b0;
        #12;
        check_outputs("reset");
        rst_n_i = 1'b1;
        idle(1);
        bus.en_i = 1'b1;
        idle(1);                       // IDLE -> FIRST

        // len=4, consecutive samples.
        bus.len_i = 8'd4;
        send(1); send(2); send(3); send(4);
        check_val("sum4.data",  int'($signed(bus.data_o)), 10);
        check_val("sum4.valid", int'(bus.valid_o), 1);
        idle(1);

        // len=4 with 0-3 idle cycles between samples.
        for (int k = 1; k <= 4; k++) begin
            send(k);
            idle($urandom_range(0, 3));
        end
        check_val("gap.data", int'($signed(bus.data_o)), 10);

        // len=2 back-to-back frames.
        bus.len_i = 8'd2;
        send(5); send(5);
        check_val("b2b.first", int'($signed(bus.data_o)), 10);
        send(-3); send(-4);
        check_val("b2b.second", int'($signed(bus.data_o)), -7);

        // len=0 behaves as 1.
        bus.len_i = 8'd0;
        for (int k = 0; k < 3; k++) begin
            send(7);
            check_val("len0.valid", int'(bus.valid_o), 1);
        end
        check_val("len0.data", int'($signed(bus.data_o)), 7);

        // Overflow: ten samples of +15.
        bus.len_i = 8'd10;
        for (int k = 0; k < 10; k++) send(15);
`ifdef INTEGRATE_DUMP_SATURATE_EN
        check_val("ovf.data", int'($signed(bus.data_o)), 127);
`else
        check_val("ovf.data", int'($signed(bus.data_o)), -106);
`endif
        check_val("ovf.flag", int'(bus.ovf_o), 1);
        bus.en_i = 1'b0;
        idle(1);
        check_val("ovf.clear", int'(bus.ovf_o), 0);
        bus.en_i = 1'b1;
        idle(1);

        // en_i dropped mid-frame discards the partial frame.
        bus.len_i = 8'd4;
        send(3); send(3);
        bus.en_i = 1'b0;
        idle(1);
        bus.en_i = 1'b1;
        idle(1);
        send(1); send(1); send(1); send(1);
        check_val("endrop.data", int'($signed(bus.data_o)), 4);

        // len_i change mid-frame applies to the next frame.
        bus.len_i = 8'd3;
        send(1);
        bus.len_i = 8'd2;
        send(2);
        check_val("lenchg.nopulse", int'(bus.valid_o), 0);
        send(3);
        check_val("lenchg.first", int'($signed(bus.data_o)), 6);
        send(4); send(5);
        check_val("lenchg.second", int'($signed(bus.data_o)), 9);

        // Asynchronous reset between edges mid-frame.
        send(9);
        #2;
        rst_n_i = 1'b0;
        #1;
        model_reset();
        check_outputs("arst");
        idle(1);
        rst_n_i = 1'b1;
        idle(1);                       // IDLE -> FIRST
        send(6); send(-2);
        check_val("arst.after", int'($signed(bus.data_o)), 4);

        // Randomized stream against the model.
        for (int i = 0; i < 2000; i++) begin
            bus.en_i    = ($urandom_range(0, 99) < 97);
            bus.valid_i = ($urandom_range(0, 99) < 60);
            bus.data_i  = I_BW'($urandom);
            if ($urandom_range(0, 39) == 0) bus.len_i = CNT_BW'($urandom_range(0, 6));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
